// File: rtl/line_buff_ctrl.sv
// line_buff_ctrl: ping-pong line-buffer controller with priming, frame alignment, tile indexing and underrun detection
module line_buff_ctrl #(
  parameter int WIDTH_PX       = 640,
  parameter int HEIGHT_PX      = 480,
  parameter int TILE_WIDTH     = 4,
  parameter int TILE_PER_LINE  = WIDTH_PX / TILE_WIDTH,
  parameter int TILE_ROWS      = HEIGHT_PX / TILE_WIDTH,
  parameter int TILE_CTR_WIDTH = $clog2(TILE_PER_LINE),
  parameter int CTR_WIDTH      = 10,
  parameter int REQ_GAP        = 3
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      pxl_en_i,
  input  logic [CTR_WIDTH-1:0]      h_ctr_i,
  input  logic [CTR_WIDTH-1:0]      v_ctr_i,
  input  logic [1:0]                buff_fill_done_i,
  output logic [1:0]                buff_fill_req_o,
  output logic [1:0]                buff_sel_o,
  output logic [TILE_CTR_WIDTH-1:0] disp_pxl_id_o,
  output logic                      underrun_o
);
  typedef enum logic [2:0] {FILL0, GAP0, FILL1, SYNC, DISP, STALL} state_t;
  localparam int GW = $clog2(REQ_GAP + 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(REQ_GAP - 1);
  localparam int ROW_LINES = TILE_ROWS * TILE_WIDTH;
  state_t state;
  logic disp_buf, busy, req_buf, pend, done_hit, swap;
  logic [GW-1:0] gap_ctr;
  // Only a done for the buffer with an outstanding request counts.
  assign done_hit = busy && buff_fill_done_i[req_buf];
  assign swap = pxl_en_i && h_ctr_i == CTR_WIDTH'(WIDTH_PX - 1) && v_ctr_i < CTR_WIDTH'(ROW_LINES) &&
                (v_ctr_i % CTR_WIDTH'(TILE_WIDTH)) == CTR_WIDTH'(TILE_WIDTH - 1);
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state           <= FILL0;
      disp_buf        <= 1'b0;
      busy            <= 1'b0;
      req_buf         <= 1'b0;
      pend            <= 1'b0;
      gap_ctr         <= '0;
      buff_fill_req_o <= '0;
      buff_sel_o      <= '0;
      disp_pxl_id_o   <= '0;
      underrun_o      <= 1'b0;
    end else begin
      buff_fill_req_o <= '0;
      disp_pxl_id_o   <= h_ctr_i < CTR_WIDTH'(WIDTH_PX) ? TILE_CTR_WIDTH'(h_ctr_i / CTR_WIDTH'(TILE_WIDTH)) : '0;
      if (done_hit) busy <= 1'b0;
      // A swap schedules a fill of the freed buffer after the gap counter drains.
      if (pend) begin
        if (gap_ctr == '0) begin
          buff_fill_req_o <= {~disp_buf, disp_buf};
          req_buf         <= ~disp_buf;
          busy            <= 1'b1;
          pend            <= 1'b0;
        end else gap_ctr <= gap_ctr - 1'b1;
      end
      case (state)
        FILL0:
          if (!busy) begin
            buff_fill_req_o <= 2'b01;
            req_buf         <= 1'b0;
            busy            <= 1'b1;
          end else if (done_hit) begin
            state   <= GAP0;
            gap_ctr <= GAP_LOAD;
          end
        GAP0:
          if (gap_ctr == '0) begin
            buff_fill_req_o <= 2'b10;
            req_buf         <= 1'b1;
            busy            <= 1'b1;
            state           <= FILL1;
          end else gap_ctr <= gap_ctr - 1'b1;
        FILL1: if (done_hit) state <= SYNC;
        SYNC:
          if (pxl_en_i && v_ctr_i >= CTR_WIDTH'(HEIGHT_PX)) begin
            state      <= DISP;
            disp_buf   <= 1'b0;
            buff_sel_o <= 2'b01;
          end
        DISP:
          if (swap && busy && !done_hit) begin
            underrun_o <= 1'b1;
            buff_sel_o <= '0;
            state      <= STALL;
          end else if (swap) begin
            disp_buf   <= ~disp_buf;
            buff_sel_o <= {~disp_buf, disp_buf};
            pend       <= 1'b1;
            gap_ctr    <= GAP_LOAD;
          end
        STALL:
          if (done_hit) begin
            disp_buf   <= ~disp_buf;
            buff_sel_o <= {~disp_buf, disp_buf};
            pend       <= 1'b1;
            gap_ctr    <= GAP_LOAD;
            state      <= DISP;
          end
        default: state <= FILL0;
      endcase
    end
  end
endmodule

// File: tb/tb_line_buff_ctrl.sv
// tb_line_buff_ctrl: directed checks of priming, swaps, frame sequencing, underrun and reset
module tb_line_buff_ctrl;
  logic clk, rstn, pxl_en;
  logic [9:0] h, v;
  logic [1:0] done, req, sel, last_req, prev_req, rsp_mask;
  logic [7:0] id;
  logic urun, hold, auto_rsp;
  int n_chk, n_fail, cyc, nreq, alt_err, bad_req, rsp_cnt, dly;

  line_buff_ctrl dut (
    .clk_i(clk), .rstn_i(rstn), .pxl_en_i(pxl_en), .h_ctr_i(h), .v_ctr_i(v),
    .buff_fill_done_i(done), .buff_fill_req_o(req), .buff_sel_o(sel),
    .disp_pxl_id_o(id), .underrun_o(urun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock step; also acts as the fill responder and watches request legality.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    done = 2'b00;
    if (rsp_mask != 2'b00) begin
      if (rsp_cnt > 1) rsp_cnt--;
      else if (!(hold && rsp_mask[1])) begin
        done = rsp_mask;
        rsp_mask = 2'b00;
      end
    end
    if (req != 2'b00) begin
      nreq++;
      if (req === last_req) alt_err++;
      if (!$onehot(req) || prev_req != 2'b00 || (req & sel) != 2'b00) bad_req++;
      last_req = req;
      if (auto_rsp) begin
        rsp_mask = req;
        rsp_cnt = dly;
      end
    end
    prev_req = req;
  endtask

  task automatic pix(input int hh, input int vv);
    h = 10'(hh);
    v = 10'(vv);
    pxl_en = 1'b0;
    repeat (3) tick();
    pxl_en = 1'b1;
    tick();
    pxl_en = 1'b0;
  endtask

  task automatic wait_req(output int n);
    n = 0;
    while (req == 2'b00 && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic prime();
    rstn = 1'b0; h = '0; v = '0; pxl_en = 1'b0;
    rsp_mask = '0; hold = 1'b0; auto_rsp = 1'b1; dly = 5;
    repeat (2) tick();
    rstn = 1'b1;
    repeat (40) tick();
    pix(0, 480);
  endtask

  task automatic test_reset();
    rstn = 1'b0; h = 10'd8; v = '0; pxl_en = 1'b0;
    repeat (3) tick();
    n_chk++; if (req !== 2'b00) begin n_fail++; $display("FAIL reset_req: got %b expected 00", req); end
    n_chk++; if (sel !== 2'b00) begin n_fail++; $display("FAIL reset_sel: got %b expected 00", sel); end
    n_chk++; if (id !== 8'd0) begin n_fail++; $display("FAIL reset_id: got %0d expected 0", id); end
    n_chk++; if (urun !== 1'b0) begin n_fail++; $display("FAIL reset_urun: got %b expected 0", urun); end
  endtask

  task automatic test_priming();
    int n, td, tr;
    rstn = 1'b0; h = '0; v = '0; pxl_en = 1'b0;
    auto_rsp = 1'b1; dly = 200; hold = 1'b0; rsp_mask = '0;
    repeat (2) tick();
    rstn = 1'b1;
    tick();
    n_chk++; if (req !== 2'b01) begin n_fail++; $display("FAIL prime_req0: got %b expected 01", req); end
    n = 0; td = -1; tr = -1;
    while (n < 400 && tr < 0) begin
      tick();
      n++;
      if (done[0]) td = cyc;
      if (req != 2'b00) tr = cyc;
    end
    n_chk++; if (req !== 2'b10) begin n_fail++; $display("FAIL prime_req1: got %b expected 10", req); end
    n_chk++; if (td < 0 || tr - td < 3) begin n_fail++; $display("FAIL prime_gap: got %0d expected >=3", tr - td); end
    n_chk++; if (sel !== 2'b00) begin n_fail++; $display("FAIL prime_sel: got %b expected 00", sel); end
    repeat (220) tick();
    pix(639, 479);
    n_chk++; if (sel !== 2'b00) begin n_fail++; $display("FAIL sync_hold: got %b expected 00", sel); end
    pix(0, 480);
    n_chk++; if (sel !== 2'b01) begin n_fail++; $display("FAIL sync_sel: got %b expected 01", sel); end
  endtask

  task automatic test_line_swap();
    int n;
    dly = 20;
    pix(5, 0);
    n_chk++; if (id !== 8'd1) begin n_fail++; $display("FAIL tile_trunc: got %0d expected 1", id); end
    pix(0, 0);
    n_chk++; if (id !== 8'd0) begin n_fail++; $display("FAIL tile_h0: got %0d expected 0", id); end
    pix(639, 0);
    n_chk++; if (id !== 8'd159) begin n_fail++; $display("FAIL tile_h639: got %0d expected 159", id); end
    n_chk++; if (sel !== 2'b01) begin n_fail++; $display("FAIL no_swap_line0: got %b expected 01", sel); end
    pix(700, 0);
    n_chk++; if (id !== 8'd0) begin n_fail++; $display("FAIL tile_blank: got %0d expected 0", id); end
    pix(639, 1);
    pix(639, 2);
    h = 10'd639; v = 10'd3;
    repeat (3) tick();
    pxl_en = 1'b1;
    n_chk++; if (sel !== 2'b01) begin n_fail++; $display("FAIL pre_swap_sel: got %b expected 01", sel); end
    tick();
    pxl_en = 1'b0;
    n_chk++; if (sel !== 2'b10) begin n_fail++; $display("FAIL swap_sel: got %b expected 10", sel); end
    wait_req(n);
    n_chk++; if (n != 3) begin n_fail++; $display("FAIL swap_req_gap: got %0d expected 3", n); end
    n_chk++; if (req !== 2'b01) begin n_fail++; $display("FAIL swap_req: got %b expected 01", req); end
  endtask

  task automatic test_full_frame();
    int base;
    prime();
    base = nreq; alt_err = 0; bad_req = 0;
    for (int i = 0; i < 480; i++) pix(639, i);
    repeat (20) tick();
    n_chk++; if (nreq - base != 120) begin n_fail++; $display("FAIL frame_reqs: got %0d expected 120", nreq - base); end
    n_chk++; if (alt_err != 0) begin n_fail++; $display("FAIL frame_alt: got %0d expected 0", alt_err); end
    n_chk++; if (bad_req != 0) begin n_fail++; $display("FAIL frame_req_shape: got %0d expected 0", bad_req); end
    pix(0, 480);
    pix(0, 500);
    pix(0, 0);
    n_chk++; if (sel !== 2'b01) begin n_fail++; $display("FAIL frame_wrap_sel: got %b expected 01", sel); end
    n_chk++; if (urun !== 1'b0) begin n_fail++; $display("FAIL frame_urun: got %b expected 0", urun); end
  endtask

  task automatic test_coincident();
    int n;
    prime();
    auto_rsp = 1'b0;
    pix(639, 3);
    repeat (6) tick();
    h = 10'd639; v = 10'd7;
    repeat (3) tick();
    pxl_en = 1'b1;
    done = 2'b01;
    tick();
    pxl_en = 1'b0;
    n_chk++; if (sel !== 2'b01) begin n_fail++; $display("FAIL coin_sel: got %b expected 01", sel); end
    n_chk++; if (urun !== 1'b0) begin n_fail++; $display("FAIL coin_urun: got %b expected 0", urun); end
    wait_req(n);
    n_chk++; if (n != 3) begin n_fail++; $display("FAIL coin_req_gap: got %0d expected 3", n); end
    n_chk++; if (req !== 2'b10) begin n_fail++; $display("FAIL coin_req: got %b expected 10", req); end
    auto_rsp = 1'b1;
  endtask

  task automatic test_underrun();
    int n;
    prime();
    hold = 1'b1;
    pix(639, 3);
    repeat (10) tick();
    pix(639, 7);
    n_chk++; if (sel !== 2'b01) begin n_fail++; $display("FAIL urun_pre_sel: got %b expected 01", sel); end
    repeat (10) tick();
    pix(639, 11);
    n_chk++; if (urun !== 1'b1) begin n_fail++; $display("FAIL urun_set: got %b expected 1", urun); end
    n_chk++; if (sel !== 2'b00) begin n_fail++; $display("FAIL urun_sel: got %b expected 00", sel); end
    repeat (5) tick();
    n_chk++; if (sel !== 2'b00) begin n_fail++; $display("FAIL stall_hold: got %b expected 00", sel); end
    hold = 1'b0;
    tick();
    tick();
    n_chk++; if (sel !== 2'b10) begin n_fail++; $display("FAIL stall_release_sel: got %b expected 10", sel); end
    wait_req(n);
    n_chk++; if (n != 3) begin n_fail++; $display("FAIL stall_req_gap: got %0d expected 3", n); end
    n_chk++; if (req !== 2'b01) begin n_fail++; $display("FAIL stall_req: got %b expected 01", req); end
    repeat (10) tick();
    pix(639, 15);
    n_chk++; if (urun !== 1'b1) begin n_fail++; $display("FAIL urun_sticky: got %b expected 1", urun); end
    n_chk++; if (sel !== 2'b01) begin n_fail++; $display("FAIL post_stall_sel: got %b expected 01", sel); end
  endtask

  task automatic test_reset_mid();
    h = 10'd100; v = 10'd20;
    tick();
    tick();
    n_chk++; if (id !== 8'd25) begin n_fail++; $display("FAIL pre_rst_id: got %0d expected 25", id); end
    #2 rstn = 1'b0;
    #1;
    n_chk++; if (req !== 2'b00) begin n_fail++; $display("FAIL rst_mid_req: got %b expected 00", req); end
    n_chk++; if (sel !== 2'b00) begin n_fail++; $display("FAIL rst_mid_sel: got %b expected 00", sel); end
    n_chk++; if (id !== 8'd0) begin n_fail++; $display("FAIL rst_mid_id: got %0d expected 0", id); end
    n_chk++; if (urun !== 1'b0) begin n_fail++; $display("FAIL rst_mid_urun: got %b expected 0", urun); end
    tick();
    tick();
    rstn = 1'b1;
    tick();
    n_chk++; if (req !== 2'b01) begin n_fail++; $display("FAIL restart_req: got %b expected 01", req); end
  endtask

  initial begin
    n_chk = 0; n_fail = 0; cyc = 0; nreq = 0; alt_err = 0; bad_req = 0;
    last_req = '0; prev_req = '0; rsp_mask = '0; rsp_cnt = 0; dly = 5;
    hold = 1'b0; auto_rsp = 1'b1; done = '0;
    rstn = 1'b0; pxl_en = 1'b0; h = '0; v = '0;
    test_reset();
    test_priming();
    test_line_swap();
    test_full_frame();
    test_coincident();
    test_underrun();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end
endmodule
